// File: rtl/dsc_stream_pkg.sv
// Shared types and sizing helpers for the deterministic stochastic-computing
// stream generators and their consumers.
package dsc_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FIN    = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 5;
  localparam int DEFAULT_NUM_INPUTS = 2;

  // Counter width: one DATA_WIDTH digit per input stream.
  function automatic int cnt_width(input int dw, input int ni);
    return dw * ni;
  endfunction

  // Full stream length L = 2^(dw*ni).
  function automatic int stream_len(input int dw, input int ni);
    return 32'd1 << (dw * ni);
  endfunction

endpackage

// File: rtl/dsc_unary_cmp.sv
// One unary bit of a clock-division stream: the digit/operand compare,
// forced low when the cycle is not a valid stream bit.
module dsc_unary_cmp #(
  parameter int DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] digit,
  input  logic [DATA_WIDTH-1:0] opnd,
  input  logic                  valid,
  output logic                  bit_out
);

  always_comb begin
    bit_out = valid & (digit < opnd);
  end

endmodule

// File: rtl/dsc_clkdiv_stream_gen.sv
// Binary-to-bitstream encoder: latches NUM_INPUTS operands and emits one unary
// bit per input per enabled cycle in clock-division order over L cycles.
module dsc_clkdiv_stream_gen
  import dsc_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS-1:0],
  output logic                  busy,
  output logic [NUM_INPUTS-1:0] stream_out,
  output logic                  stream_valid,
  output logic                  stream_last,
  output logic                  done
);

  localparam int CNT_W = cnt_width(DATA_WIDTH, NUM_INPUTS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(stream_len(DATA_WIDTH, NUM_INPUTS) - 1);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] opnd_reg [NUM_INPUTS-1:0];
  logic                  accept;
  logic                  cnt_at_last;

  assign accept      = (state_reg == IDLE) & load;
  assign cnt_at_last = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          state_next = STREAM;
          cnt_next   = '0;
        end
      end
      STREAM: begin
        if (en) begin
          // The counter wraps to zero naturally on the final bit.
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_at_last) begin
            state_next = FIN;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy         = (state_reg == STREAM);
    stream_valid = (state_reg == STREAM) & en;
    stream_last  = (state_reg == STREAM) & en & cnt_at_last;
    done         = (state_reg == FIN);
  end

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          opnd_reg[gi] <= '0;
        end else if (accept) begin
          opnd_reg[gi] <= bin_data_in[gi];
        end
      end

      // Lane gi sees digit gi of the counter, so it holds each value for N^gi cycles.
      dsc_unary_cmp #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_cmp (
        .digit  (cnt_reg[DATA_WIDTH*gi +: DATA_WIDTH]),
        .opnd   (opnd_reg[gi]),
        .valid  (stream_valid),
        .bit_out(stream_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_dsc_clkdiv_stream_gen.sv
// Directed bench for the clock-division stream generator: a 2x2-bit instance
// for the detailed scenarios and a 3x3-bit instance for product exactness.
module tb_dsc_clkdiv_stream_gen;

  localparam int AW = 2;
  localparam int AN = 2;
  localparam int BW = 3;
  localparam int BN = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          a_en = 1'b0;
  logic          a_load = 1'b0;
  logic [AW-1:0] a_data [AN-1:0];
  logic          a_busy, a_valid, a_last, a_done;
  logic [AN-1:0] a_out;

  logic          b_en = 1'b0;
  logic          b_load = 1'b0;
  logic [BW-1:0] b_data [BN-1:0];
  logic          b_busy, b_valid, b_last, b_done;
  logic [BN-1:0] b_out;

  int checks = 0;
  int failures = 0;

  logic [15:0] cap_s0, cap_s1;
  int cap_vcnt, cap_and, cap_busy, cap_last_cyc, cap_last_cnt;
  int cap_done_cyc, cap_gate_err, cap_overflow, cap_stall;
  logic cap_done_seen;

  dsc_clkdiv_stream_gen #(.DATA_WIDTH(AW), .NUM_INPUTS(AN)) u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .en          (a_en),
    .load        (a_load),
    .bin_data_in (a_data),
    .busy        (a_busy),
    .stream_out  (a_out),
    .stream_valid(a_valid),
    .stream_last (a_last),
    .done        (a_done)
  );

  dsc_clkdiv_stream_gen #(.DATA_WIDTH(BW), .NUM_INPUTS(BN)) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .en          (b_en),
    .load        (b_load),
    .bin_data_in (b_data),
    .busy        (b_busy),
    .stream_out  (b_out),
    .stream_valid(b_valid),
    .stream_last (b_last),
    .done        (b_done)
  );

  always #5 clk = ~clk;

  task automatic start_a(input int x0, input int x1);
    @(negedge clk);
    a_data[0] = x0[AW-1:0];
    a_data[1] = x1[AW-1:0];
    a_load    = 1'b1;
    a_en      = 1'b1;
  endtask

  // Samples every negedge after the accepting edge; cycle 1 is the first bit cycle.
  task automatic capture(input int max_cyc, input int stall_after, input int stall_len,
                         input int load_at);
    int  rem;
    logic stall_started, ld_done;
    cap_s0 = '0; cap_s1 = '0;
    cap_vcnt = 0; cap_and = 0; cap_busy = 0; cap_last_cyc = 0; cap_last_cnt = 0;
    cap_done_cyc = 0; cap_gate_err = 0; cap_overflow = 0; cap_stall = 0;
    cap_done_seen = 1'b0;
    rem = 0; stall_started = 1'b0; ld_done = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (a_busy) cap_busy++;
      if (a_busy && !a_valid) cap_stall++;
      if (a_valid) begin
        if (cap_vcnt < 16) begin
          cap_s0[cap_vcnt] = a_out[0];
          cap_s1[cap_vcnt] = a_out[1];
        end else begin
          cap_overflow++;
        end
        if (a_out[0] && a_out[1]) cap_and++;
        if (a_last) begin
          cap_last_cyc = c;
          cap_last_cnt++;
        end
        cap_vcnt++;
      end else if (a_out != '0 || a_last) begin
        cap_gate_err++;
      end
      if (a_done) begin
        cap_done_seen = 1'b1;
        cap_done_cyc  = c;
      end
      a_load = 1'b0;
      if (load_at >= 0 && !ld_done && cap_vcnt == load_at) begin
        a_load    = 1'b1;
        a_data[0] = 2'd1;
        a_data[1] = 2'd1;
        ld_done   = 1'b1;
      end
      if (stall_len > 0 && !stall_started && cap_vcnt == stall_after + 1) begin
        a_en = 1'b0;
        rem  = stall_len;
        stall_started = 1'b1;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) a_en = 1'b1;
      end
      if (cap_done_seen) break;
    end
    checks++;
    if (!cap_done_seen) begin
      failures++;
      $display("FAIL capture_timeout: done not seen within %0d cycles, valid bits %0d", max_cyc, cap_vcnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_busy, a_valid, a_last, a_done, a_out} !== 6'b0) begin
      failures++;
      $display("FAIL reset_a: busy/valid/last/done/out=%b required 000000",
               {a_busy, a_valid, a_last, a_done, a_out});
    end
    checks++;
    if ({b_busy, b_valid, b_last, b_done, b_out} !== 7'b0) begin
      failures++;
      $display("FAIL reset_b: busy/valid/last/done/out=%b required 0000000",
               {b_busy, b_valid, b_last, b_done, b_out});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", a_busy, a_done);
    end
  endtask

  task automatic test_basic();
    start_a(3, 2);
    capture(40, -1, 0, -1);
    $display("stream a0=3 a1=2 bits=%0d and_pop=%0d s0=%h s1=%h", cap_vcnt, cap_and, cap_s0, cap_s1);
    checks++;
    if (cap_s0 !== 16'h7777 || cap_s1 !== 16'h00FF) begin
      failures++;
      $display("FAIL basic_bits: s0=%h s1=%h required 7777 00ff", cap_s0, cap_s1);
    end
    checks++;
    if (cap_and != 6 || cap_vcnt != 16 || cap_overflow != 0) begin
      failures++;
      $display("FAIL basic_pop: and=%0d bits=%0d required 6 16", cap_and, cap_vcnt);
    end
    checks++;
    if (cap_last_cyc != 16 || cap_last_cnt != 1 || cap_done_cyc != 17) begin
      failures++;
      $display("FAIL basic_timing: last_cyc=%0d last_cnt=%0d done_cyc=%0d required 16 1 17",
               cap_last_cyc, cap_last_cnt, cap_done_cyc);
    end
    checks++;
    if (cap_busy != 16 || cap_gate_err != 0) begin
      failures++;
      $display("FAIL basic_busy: busy_cycles=%0d gate_err=%0d required 16 0", cap_busy, cap_gate_err);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b busy=%b required 0 0", a_done, a_busy);
    end
  endtask

  task automatic test_zero_operand();
    start_a(0, 3);
    capture(40, -1, 0, -1);
    $display("stream a0=0 a1=3 bits=%0d and_pop=%0d s0=%h s1=%h", cap_vcnt, cap_and, cap_s0, cap_s1);
    checks++;
    if (cap_s0 !== 16'h0000 || cap_s1 !== 16'h0FFF || cap_and != 0) begin
      failures++;
      $display("FAIL zero_bits: s0=%h s1=%h and=%0d required 0000 0fff 0", cap_s0, cap_s1, cap_and);
    end
    checks++;
    if (cap_vcnt != 16 || cap_done_cyc != 17) begin
      failures++;
      $display("FAIL zero_len: bits=%0d done_cyc=%0d required 16 17", cap_vcnt, cap_done_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    start_a(2, 1);
    capture(40, 5, 3, -1);
    $display("stream a0=2 a1=1 stall=3 bits=%0d and_pop=%0d s0=%h s1=%h", cap_vcnt, cap_and, cap_s0, cap_s1);
    checks++;
    if (cap_s0 !== 16'h3333 || cap_s1 !== 16'h000F || cap_and != 2) begin
      failures++;
      $display("FAIL stall_bits: s0=%h s1=%h and=%0d required 3333 000f 2", cap_s0, cap_s1, cap_and);
    end
    checks++;
    if (cap_stall != 3 || cap_gate_err != 0 || cap_vcnt != 16) begin
      failures++;
      $display("FAIL stall_valid: stall_cycles=%0d gate_err=%0d bits=%0d required 3 0 16",
               cap_stall, cap_gate_err, cap_vcnt);
    end
    checks++;
    if (cap_last_cyc != 19 || cap_done_cyc != 20 || cap_busy != 19) begin
      failures++;
      $display("FAIL stall_timing: last_cyc=%0d done_cyc=%0d busy=%0d required 19 20 19",
               cap_last_cyc, cap_done_cyc, cap_busy);
    end
    @(negedge clk);
  endtask

  task automatic test_load_ignored();
    start_a(3, 3);
    capture(40, -1, 0, 9);
    $display("stream a0=3 a1=3 reload@9 bits=%0d and_pop=%0d s0=%h s1=%h", cap_vcnt, cap_and, cap_s0, cap_s1);
    checks++;
    if (cap_s0 !== 16'h7777 || cap_s1 !== 16'h0FFF || cap_and != 9 || cap_done_cyc != 17) begin
      failures++;
      $display("FAIL midload_ignored: s0=%h s1=%h and=%0d done_cyc=%0d required 7777 0fff 9 17",
               cap_s0, cap_s1, cap_and, cap_done_cyc);
    end
    // Load held through the done cycle: ignored in FIN, accepted from IDLE.
    a_load    = 1'b1;
    a_data[0] = 2'd1;
    a_data[1] = 2'd1;
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL fin_load: busy=%b done=%b required 0 0", a_busy, a_done);
    end
    capture(40, -1, 0, -1);
    $display("stream a0=1 a1=1 bits=%0d and_pop=%0d s0=%h s1=%h", cap_vcnt, cap_and, cap_s0, cap_s1);
    checks++;
    if (cap_s0 !== 16'h1111 || cap_s1 !== 16'h000F || cap_and != 1 || cap_done_cyc != 17) begin
      failures++;
      $display("FAIL idle_load: s0=%h s1=%h and=%0d done_cyc=%0d required 1111 000f 1 17",
               cap_s0, cap_s1, cap_and, cap_done_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int vcnt;
    int done_hits;
    vcnt = 0;
    done_hits = 0;
    start_a(3, 3);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a_load = 1'b0;
      if (a_valid) vcnt++;
      if (vcnt == 7) break;
    end
    @(negedge clk);
    checks++;
    if (a_valid !== 1'b1 || vcnt != 7) begin
      failures++;
      $display("FAIL abort_setup: valid=%b bits_before=%0d required 1 7", a_valid, vcnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_valid, a_last, a_done, a_out} !== 6'b0) begin
      failures++;
      $display("FAIL abort_immediate: busy/valid/last/done/out=%b required 000000",
               {a_busy, a_valid, a_last, a_done, a_out});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (a_done) done_hits++;
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (a_done || a_busy) done_hits++;
    end
    checks++;
    if (done_hits != 0) begin
      failures++;
      $display("FAIL abort_no_done: done/busy cycles=%0d required 0", done_hits);
    end
    start_a(1, 1);
    capture(40, -1, 0, -1);
    $display("stream after reset a0=1 a1=1 bits=%0d and_pop=%0d", cap_vcnt, cap_and);
    checks++;
    if (cap_and != 1 || cap_vcnt != 16) begin
      failures++;
      $display("FAIL abort_recover: and=%0d bits=%0d required 1 16", cap_and, cap_vcnt);
    end
    @(negedge clk);
  endtask

  task automatic run_b(input int x0, input int x1, input int x2);
    int vcnt, andp, p0, p1, p2;
    logic seen;
    vcnt = 0; andp = 0; p0 = 0; p1 = 0; p2 = 0; seen = 1'b0;
    @(negedge clk);
    b_data[0] = x0[BW-1:0];
    b_data[1] = x1[BW-1:0];
    b_data[2] = x2[BW-1:0];
    b_load = 1'b1;
    b_en   = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      b_load = 1'b0;
      if (b_valid) begin
        vcnt++;
        if (b_out == 3'b111) andp++;
        if (b_out[0]) p0++;
        if (b_out[1]) p1++;
        if (b_out[2]) p2++;
      end
      if (b_done) begin
        seen = 1'b1;
        break;
      end
    end
    $display("wide a0=%0d a1=%0d a2=%0d bits=%0d and_pop=%0d pops=%0d/%0d/%0d",
             x0, x1, x2, vcnt, andp, p0, p1, p2);
    checks++;
    if (!seen || vcnt != 512) begin
      failures++;
      $display("FAIL wide_len: done_seen=%b bits=%0d required 1 512", seen, vcnt);
    end
    checks++;
    if (andp != x0 * x1 * x2) begin
      failures++;
      $display("FAIL wide_product: and_pop=%0d required %0d", andp, x0 * x1 * x2);
    end
    checks++;
    if (p0 != x0 * 64 || p1 != x1 * 64 || p2 != x2 * 64) begin
      failures++;
      $display("FAIL wide_stream_pop: %0d/%0d/%0d required %0d/%0d/%0d",
               p0, p1, p2, x0 * 64, x1 * 64, x2 * 64);
    end
    @(negedge clk);
  endtask

  task automatic test_wide();
    run_b(0, 0, 0);
    run_b(7, 7, 7);
    run_b(7, 0, 5);
    run_b(1, 1, 1);
    run_b(3, 6, 2);
    for (int k = 0; k < 15; k++) begin
      run_b(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)), int'($urandom_range(7, 0)));
    end
  endtask

  initial begin
    a_data[0] = '0; a_data[1] = '0;
    b_data[0] = '0; b_data[1] = '0; b_data[2] = '0;
    test_reset();
    test_basic();
    test_zero_operand();
    test_stall();
    test_load_ignored();
    test_reset_abort();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
